fp_special_pipe: RTL and testbench
==================================

Name: fp_special_pipe

Overview:
- Parametrised, pipelined special-operand resolver for the floating-point multiply/divide datapath.
- Operates on sign-less magnitudes {exp, man}; the sign is handled elsewhere.
- Classifies both operands and overrides the core arithmetic result for zero, Inf and NaN cases.
- Provides per-result and sticky exception flags, a saturating exception counter, and valid/ready flow control.

Parameters:
- EXP_W, 8, exponent width.
- MAN_W, 23, mantissa width; word width W = EXP_W+MAN_W.
- CNT_W, 8, width of saturating exception counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  operand/result beat valid.
- in_ready  out  1  stage 1 can accept a beat.
- op_div  in  1  0 = multiply, 1 = divide (a/b).
- a  in  W  operand A magnitude.
- b  in  W  operand B magnitude.
- core_res  in  W  core datapath result for the same a, b.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out  out  W  resolved magnitude.
- err_nan  out  1  out is NaN; qualified by out_valid.
- err_dz  out  1  divide-by-zero on this result; qualified by out_valid.
- special  out  1  out was overridden, i.e. not core_res.
- sticky_nan  out  1  sticky OR of accepted err_nan.
- sticky_dz  out  1  sticky OR of accepted err_dz.
- err_cnt  out  CNT_W  count of accepted results with err_nan|err_dz; saturates at all-ones.
- err_clr  in  1  synchronous clear of sticky flags and counter.

Behaviour:
- Classes (exp all-ones = E1):
  - ZERO: exp==0; denormals flush to zero.
  - INF: exp==E1 and man==0.
  - NAN: exp==E1 and man!=0.
  - NORM: all other values.
- Canonical outputs:
  - ZERO = all 0.
  - INF = E1 with man 0.
  - QNAN = all 1.
- Multiply priority (first match wins):
  1. Any NAN -> QNAN.
  2. ZERO×INF or INF×ZERO -> QNAN.
  3. Any INF -> INF.
  4. Any ZERO -> ZERO.
  5. Otherwise -> core_res.
- Divide priority (first match wins):
  1. Any NAN -> QNAN.
  2. 0/0 or Inf/Inf -> QNAN.
  3. a INF -> INF.
  4. b ZERO (a NORM) -> INF with err_dz=1.
  5. a ZERO -> ZERO.
  6. b INF -> ZERO.
  7. Otherwise -> core_res.
- Flags:
  - err_nan = (out == QNAN from the rules above), or core_res is itself NAN on the pass-through path.
  - special=1 on every override path.
- Pipeline:
  - Stage 1 registers the classes, op_div, core_res and the beat's valid.
  - Stage 2 registers out and the flags.
  - Latency: 2 cycles from in_valid&&in_ready to out_valid with no stall.
  - Throughput: 1 beat per cycle.
- Flow control:
  - A stage advances when its successor is empty or being drained.
  - in_ready = !s1_valid || !s2_valid || out_ready.
  - out, flags and out_valid hold stable while out_valid && !out_ready.
  - No beat is dropped or duplicated.
- Sticky flags and counter update on output acceptance only (out_valid && out_ready).
  - err_cnt increments by 1 per accepted erroneous result.
  - err_cnt holds at 2^CNT_W-1.
- err_clr coincident with an accepted error: clear wins; flags and counter become 0 that cycle.
- Reset (async, any time including mid-stream):
  - s1_valid, s2_valid and out_valid go to 0.
  - out, err_nan, err_dz and special go to 0.
  - Sticky flags and err_cnt go to 0.
  - In-flight beats are discarded.
  - in_ready reads 1 in reset and after release.

Decomposition:
- Package fp_special_pkg holds:
  - fp_class enum (ZERO, NORM, INF, NAN; 2 bits).
  - Functions/constants for canonical ZERO, INF and QNAN built from EXP_W/MAN_W.
- Sub-module fp_classify: combinational, one operand -> fp_class. Instantiated twice in stage 0.
- Resolution priority logic and the pipeline/flow control stay in fp_special_pipe.

Test Plan (EXP_W=8, MAN_W=23):
- Mul 3F800000×7F800000, core_res 40000000 -> out 7F800000 two cycles later; special=1; err_nan=0.
- Mul 00000000×7F800000 -> out 7FFFFFFF, err_nan=1; sticky_nan=1 and err_cnt=1 after acceptance. Div 3F800000/00000000 -> out 7F800000, err_dz=1.
- Mul 3F800000×40000000, core_res 40000000 -> out 40000000, special=0. Div 7F800000/7F800000 -> 7FFFFFFF. Div 3F800000/7F800000 -> 00000000.
- Stream 6 back-to-back beats with out_ready low for cycles 3-6:
  - in_ready drops once both stages are full.
  - out holds stable during the stall.
  - All 6 results emerge in order, none lost.
- CNT_W=2: 5 NaN results -> err_cnt saturates at 3. err_clr in the same cycle as a 6th accepted NaN -> counter 0, sticky_nan 0.
- Assert rst with 2 beats in flight -> out_valid=0 immediately and counters 0. After release, a new beat yields a correct result in 2 cycles.

Source files
------------

// File: rtl/fp_special_pkg.sv
// Shared types and canonical encodings for the FP special-operand resolver.
package fp_special_pkg;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        NORM = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fp_class;

    localparam int unsigned MAX_W = 64;

    // Canonical zero is width-independent; truncate to the word width at use.
    localparam logic [MAX_W-1:0] FP_ZERO_WORD = '0;

    function automatic logic [MAX_W-1:0] fp_inf(input int unsigned ew, input int unsigned mw);
        logic [MAX_W-1:0] e1;
        e1 = (MAX_W'(1) << ew) - MAX_W'(1);
        return e1 << mw;
    endfunction

    function automatic logic [MAX_W-1:0] fp_qnan(input int unsigned ew, input int unsigned mw);
        return (MAX_W'(1) << (ew + mw)) - MAX_W'(1);
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier; denormals are flushed to ZERO.
module fp_classify
    import fp_special_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic [EXP_W+MAN_W-1:0] x,
    output fp_class                cls_c
);

    logic [EXP_W-1:0] ex;
    logic [MAN_W-1:0] mn;

    assign ex = x[EXP_W+MAN_W-1:MAN_W];
    assign mn = x[MAN_W-1:0];

    always_comb begin
        cls_c = NORM;
        if (ex == '0) begin
            cls_c = ZERO;
        end else if (&ex) begin
            cls_c = (mn == '0) ? INF : NAN;
        end
    end

endmodule

// File: rtl/fp_special_pipe.sv
// Two-stage special-operand resolver for FP multiply/divide with sticky flags
// and a saturating error counter.
module fp_special_pipe
    import fp_special_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    parameter int unsigned CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   op_div,
    input  logic [EXP_W+MAN_W-1:0] a,
    input  logic [EXP_W+MAN_W-1:0] b,
    input  logic [EXP_W+MAN_W-1:0] core_res,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W-1:0] out,
    output logic                   err_nan,
    output logic                   err_dz,
    output logic                   special,
    output logic                   sticky_nan,
    output logic                   sticky_dz,
    output logic [CNT_W-1:0]       err_cnt,
    input  logic                   err_clr
);

    localparam int unsigned W = EXP_W + MAN_W;
    localparam logic [W-1:0] CANON_ZERO = W'(FP_ZERO_WORD);
    localparam logic [W-1:0] CANON_INF  = W'(fp_inf(EXP_W, MAN_W));
    localparam logic [W-1:0] CANON_QNAN = W'(fp_qnan(EXP_W, MAN_W));

    fp_class        cls_a_c;
    fp_class        cls_b_c;

    logic           s1_valid;
    logic           s1_div;
    fp_class        s1_ca;
    fp_class        s1_cb;
    logic [W-1:0]   s1_core;

    logic           s1_en;
    logic           s2_en;
    logic           accept;

    logic [W-1:0]   res_c;
    logic           nan_c;
    logic           dz_c;
    logic           spc_c;
    logic           core_nan_c;

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (.x(a), .cls_c(cls_a_c));
    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (.x(b), .cls_c(cls_b_c));

    // Each stage advances when the stage after it is empty or draining.
    assign s2_en    = !out_valid || out_ready;
    assign s1_en    = !s1_valid || s2_en;
    assign in_ready = s1_en;
    assign accept   = out_valid && out_ready;

    assign core_nan_c = (&s1_core[W-1:MAN_W]) && (|s1_core[MAN_W-1:0]);

    always_comb begin
        res_c = CANON_QNAN;
        nan_c = 1'b0;
        dz_c  = 1'b0;
        spc_c = 1'b1;
        if (s1_ca == NAN || s1_cb == NAN) begin
            nan_c = 1'b1;
        end else if (!s1_div) begin
            if ((s1_ca == ZERO && s1_cb == INF) || (s1_ca == INF && s1_cb == ZERO)) begin
                nan_c = 1'b1;
            end else if (s1_ca == INF || s1_cb == INF) begin
                res_c = CANON_INF;
            end else if (s1_ca == ZERO || s1_cb == ZERO) begin
                res_c = CANON_ZERO;
            end else begin
                res_c = s1_core;
                nan_c = core_nan_c;
                spc_c = 1'b0;
            end
        end else begin
            // By the b==ZERO branch, a is neither NAN, INF nor ZERO, so a/0 is NORM/0.
            if ((s1_ca == ZERO && s1_cb == ZERO) || (s1_ca == INF && s1_cb == INF)) begin
                nan_c = 1'b1;
            end else if (s1_ca == INF) begin
                res_c = CANON_INF;
            end else if (s1_cb == ZERO) begin
                res_c = CANON_INF;
                dz_c  = 1'b1;
            end else if (s1_ca == ZERO || s1_cb == INF) begin
                res_c = CANON_ZERO;
            end else begin
                res_c = s1_core;
                nan_c = core_nan_c;
                spc_c = 1'b0;
            end
        end
    end

    // Stage 1: operand classes and core result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_div   <= 1'b0;
            s1_ca    <= ZERO;
            s1_cb    <= ZERO;
            s1_core  <= '0;
        end else if (s1_en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_div  <= op_div;
                s1_ca   <= cls_a_c;
                s1_cb   <= cls_b_c;
                s1_core <= core_res;
            end
        end
    end

    // Stage 2: resolved result and per-result flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out       <= '0;
            err_nan   <= 1'b0;
            err_dz    <= 1'b0;
            special   <= 1'b0;
        end else if (s2_en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out     <= res_c;
                err_nan <= nan_c;
                err_dz  <= dz_c;
                special <= spc_c;
            end
        end
    end

    // Sticky flags and counter track accepted results; clear has priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_nan <= 1'b0;
            sticky_dz  <= 1'b0;
            err_cnt    <= '0;
        end else if (err_clr) begin
            sticky_nan <= 1'b0;
            sticky_dz  <= 1'b0;
            err_cnt    <= '0;
        end else if (accept) begin
            sticky_nan <= sticky_nan | err_nan;
            sticky_dz  <= sticky_dz | err_dz;
            if ((err_nan || err_dz) && (err_cnt != '1)) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fp_special_pipe.sv
// Directed-vector bench for fp_special_pipe (single-precision, 2-bit counter).
module tb_fp_special_pipe;

    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned W     = EXP_W + MAN_W;
    localparam logic [31:0] QNAN  = 32'h7FFF_FFFF;
    localparam logic [31:0] PINF  = 32'h7F80_0000;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             op_div;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [W-1:0]     core_res;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out;
    logic             err_nan;
    logic             err_dz;
    logic             special;
    logic             sticky_nan;
    logic             sticky_dz;
    logic [CNT_W-1:0] err_cnt;
    logic             err_clr;

    int n_vec = 0;
    int n_bad = 0;

    fp_special_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_div(op_div), .a(a), .b(b), .core_res(core_res),
        .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .err_nan(err_nan), .err_dz(err_dz), .special(special),
        .sticky_nan(sticky_nan), .sticky_dz(sticky_dz),
        .err_cnt(err_cnt), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push one beat, wait the two-cycle latency and check the pending result.
    task automatic run_one(input logic od, input logic [31:0] va, input logic [31:0] vb,
                           input logic [31:0] vc, input logic [31:0] e_out,
                           input logic e_nan, input logic e_dz, input logic e_spc,
                           input string tag);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op_div    = od;
        a         = W'(va);
        b         = W'(vb);
        core_res  = W'(vc);
        step();
        in_valid = 1'b0;
        step();
        check({tag, ".valid"},   32'(out_valid), 32'd1);
        check({tag, ".out"},     32'(out),       e_out);
        check({tag, ".err_nan"}, 32'(err_nan),   32'(e_nan));
        check({tag, ".err_dz"},  32'(err_dz),    32'(e_dz));
        check({tag, ".special"}, 32'(special),   32'(e_spc));
    endtask

    logic        s_op  [6];
    logic [31:0] s_a   [6];
    logic [31:0] s_b   [6];
    logic [31:0] s_c   [6];
    logic [31:0] s_exp [6];

    initial begin
        int nin;
        int nout;
        logic hold;
        logic saw_block;
        logic [31:0] prev;

        s_op[0] = 1'b0; s_a[0] = 32'h3F80_0000; s_b[0] = 32'h4000_0000; s_c[0] = 32'h4000_0001; s_exp[0] = 32'h4000_0001;
        s_op[1] = 1'b0; s_a[1] = 32'h3F80_0000; s_b[1] = 32'h4000_0000; s_c[1] = 32'h4000_0002; s_exp[1] = 32'h4000_0002;
        s_op[2] = 1'b0; s_a[2] = 32'h0000_0000; s_b[2] = 32'h3F80_0000; s_c[2] = 32'h1234_5678; s_exp[2] = 32'h0000_0000;
        s_op[3] = 1'b1; s_a[3] = 32'h7F80_0000; s_b[3] = 32'h3F80_0000; s_c[3] = 32'h0000_0000; s_exp[3] = PINF;
        s_op[4] = 1'b0; s_a[4] = 32'h7FC0_0000; s_b[4] = 32'h3F80_0000; s_c[4] = 32'h0000_0000; s_exp[4] = QNAN;
        s_op[5] = 1'b1; s_a[5] = 32'h3F80_0000; s_b[5] = 32'h4000_0000; s_c[5] = 32'h3F00_0000; s_exp[5] = 32'h3F00_0000;

        rst = 1'b1; in_valid = 1'b0; op_div = 1'b0; a = '0; b = '0; core_res = '0;
        out_ready = 1'b1; err_clr = 1'b0;
        repeat (2) step();
        check("rst.in_ready",  32'(in_ready),  32'd1);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.out",       32'(out),       32'd0);
        check("rst.err_cnt",   32'(err_cnt),   32'd0);
        check("rst.sticky",    32'({sticky_nan, sticky_dz}), 32'd0);
        rst = 1'b0;
        step();
        check("rel.in_ready", 32'(in_ready), 32'd1);

        run_one(1'b0, 32'h3F80_0000, PINF, 32'h4000_0000, PINF, 1'b0, 1'b0, 1'b1, "mul_1xinf");
        step();
        run_one(1'b0, 32'h0000_0000, PINF, 32'h0000_0000, QNAN, 1'b1, 1'b0, 1'b1, "mul_0xinf");
        step();
        check("acc1.sticky_nan", 32'(sticky_nan), 32'd1);
        check("acc1.err_cnt",    32'(err_cnt),    32'd1);
        run_one(1'b1, 32'h3F80_0000, 32'h0000_0000, 32'h0000_0000, PINF, 1'b0, 1'b1, 1'b1, "div_by_0");
        step();
        check("acc2.sticky_dz", 32'(sticky_dz), 32'd1);
        check("acc2.err_cnt",   32'(err_cnt),   32'd2);
        run_one(1'b0, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0, 1'b0, "mul_pass");
        step();
        run_one(1'b1, PINF, PINF, 32'h0000_0000, QNAN, 1'b1, 1'b0, 1'b1, "div_inf_inf");
        step();
        check("acc3.err_cnt", 32'(err_cnt), 32'd3);
        run_one(1'b1, 32'h3F80_0000, PINF, 32'h1234_5678, 32'h0, 1'b0, 1'b0, 1'b1, "div_by_inf");
        step();
        run_one(1'b0, 32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000, 32'h0, 1'b0, 1'b0, 1'b1, "mul_denorm");
        step();
        run_one(1'b0, 32'h3F80_0000, 32'h4000_0000, 32'h7FC0_0000, 32'h7FC0_0000, 1'b1, 1'b0, 1'b0, "mul_core_nan");
        step();
        run_one(1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, QNAN, 1'b1, 1'b0, 1'b1, "div_0_0");
        step();
        run_one(1'b1, 32'h0000_0000, 32'h3F80_0000, 32'h0000_0005, 32'h0, 1'b0, 1'b0, 1'b1, "div_0_by_x");
        step();
        check("sat_a.err_cnt", 32'(err_cnt), 32'd3);

        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("clr.err_cnt", 32'(err_cnt), 32'd0);
        check("clr.sticky",  32'({sticky_nan, sticky_dz}), 32'd0);

        for (int i = 0; i < 5; i++) begin
            run_one(1'b0, 32'h7FC0_0000, 32'h3F80_0000, 32'h0, QNAN, 1'b1, 1'b0, 1'b1, "nan_sat");
            step();
        end
        check("sat_b.err_cnt",    32'(err_cnt),    32'd3);
        check("sat_b.sticky_nan", 32'(sticky_nan), 32'd1);
        run_one(1'b0, 32'h7FC0_0000, 32'h3F80_0000, 32'h0, QNAN, 1'b1, 1'b0, 1'b1, "nan_clr");
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("clr_acc.err_cnt",    32'(err_cnt),    32'd0);
        check("clr_acc.sticky_nan", 32'(sticky_nan), 32'd0);

        // Back-to-back stream with the output stalled in cycles 3..6.
        nin = 0; nout = 0; hold = 1'b0; saw_block = 1'b0; prev = '0;
        for (int c = 0; c < 40 && nout < 6; c++) begin
            out_ready = !(c >= 3 && c <= 6);
            in_valid  = (nin < 6);
            if (nin < 6) begin
                op_div = s_op[nin]; a = W'(s_a[nin]); b = W'(s_b[nin]); core_res = W'(s_c[nin]);
            end
            #1;
            if (hold) begin
                check("stall.valid", 32'(out_valid), 32'd1);
                check("stall.out",   32'(out),       prev);
            end
            if (out_valid && out_ready) begin
                check($sformatf("stream.out%0d", nout), 32'(out), s_exp[nout]);
                nout++;
            end
            hold = out_valid && !out_ready;
            prev = 32'(out);
            if (in_valid && !in_ready) saw_block = 1'b1;
            if (in_valid && in_ready) nin++;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream.count",   32'(nout),      32'd6);
        check("stream.blocked", 32'(saw_block), 32'd1);
        check("stream.err_cnt", 32'(err_cnt),   32'd1);

        // Reset with two beats in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1; op_div = 1'b0; a = W'(32'h7FC0_0000); b = W'(32'h3F80_0000); core_res = '0;
        step();
        a = W'(32'h3F80_0000); b = W'(32'h4000_0000); core_res = W'(32'h4000_0000);
        step();
        in_valid = 1'b0;
        check("pre_rst.valid",   32'(out_valid), 32'd1);
        check("pre_rst.err_nan", 32'(err_nan),   32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst.valid",    32'(out_valid),  32'd0);
        check("mid_rst.out",      32'(out),        32'd0);
        check("mid_rst.flags",    32'({err_nan, err_dz, special}), 32'd0);
        check("mid_rst.err_cnt",  32'(err_cnt),    32'd0);
        check("mid_rst.sticky",   32'({sticky_nan, sticky_dz}), 32'd0);
        check("mid_rst.in_ready", 32'(in_ready),   32'd1);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("post_rst.valid", 32'(out_valid), 32'd0);
        run_one(1'b1, 32'h4000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0, 1'b0, "post_rst");
        step();
        check("post_rst.drain", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
